// File: rtl/toysram_cmd_arb.sv
// Round-robin arbiter/sequencer granting the Wishbone command bus (A) or the test engine (B)
// one command at a time onto a single toysram array port with fixed read latency.
module toysram_cmd_arb #(
    parameter int          RD_LAT  = 2,
    parameter int          ARR_AW  = 6,
    parameter logic [31:0] ERR_DAT = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_en,
    input  logic              a_val,
    input  logic [31:0]       a_adr,
    input  logic              a_we,
    input  logic [3:0]        a_sel,
    input  logic [31:0]       a_dat,
    output logic              a_ack,
    output logic [31:0]       a_rd_dat,
    input  logic              b_val,
    input  logic [31:0]       b_adr,
    input  logic              b_we,
    input  logic [3:0]        b_sel,
    input  logic [31:0]       b_dat,
    output logic              b_ack,
    output logic [31:0]       b_rd_dat,
    output logic              arr_en,
    output logic              arr_we,
    output logic [ARR_AW-1:0] arr_adr,
    output logic [3:0]        arr_sel,
    output logic [31:0]       arr_dat,
    input  logic [31:0]       arr_rd_dat,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int             CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0]  CNT_INIT = CW'(RD_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic          prio_q, prio_d;      // 0 = A has priority, 1 = B
    logic [1:0]    mask_q, mask_d;
    logic          gnt_q, gnt_d;        // 0 = A, 1 = B
    logic [27:2]   adr_q, adr_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   dat_q, dat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_rd_q, a_rd_d;
    logic [31:0]   b_rd_q, b_rd_d;

    logic [1:0] elig;
    logic       pick_b;
    logic       oor;
    logic       issue;
    logic       unused_adr;

    // Byte-lane and top-nibble address bits carry no meaning for the array.
    assign unused_adr = ^{a_adr[31:28], a_adr[1:0], b_adr[31:28], b_adr[1:0]};

    assign elig   = {b_val, a_val} & cfg_en & ~mask_q;
    assign pick_b = elig[1] & (~elig[0] | prio_q);
    assign oor    = |adr_q[27:ARR_AW+2];

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        mask_d  = mask_q;
        gnt_d   = gnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        cnt_d   = cnt_q;
        a_rd_d  = a_rd_q;
        b_rd_d  = b_rd_q;
        case (state_q)
            S_IDLE: begin
                mask_d = 2'b00;
                if (|elig) begin
                    gnt_d   = pick_b;
                    adr_d   = pick_b ? b_adr[27:2] : a_adr[27:2];
                    we_d    = pick_b ? b_we  : a_we;
                    sel_d   = pick_b ? b_sel : a_sel;
                    dat_d   = pick_b ? b_dat : a_dat;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_RESP;
                end else if (oor) begin
                    if (gnt_q) b_rd_d = ERR_DAT;
                    else       a_rd_d = ERR_DAT;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Read data lands directly in the requester's register so it is valid with ack.
                if (cnt_q == '0) begin
                    if (gnt_q) b_rd_d = arr_rd_dat;
                    else       a_rd_d = arr_rd_dat;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                prio_d  = ~gnt_q;
                mask_d  = gnt_q ? 2'b10 : 2'b01;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            mask_q  <= 2'b00;
            gnt_q   <= 1'b0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            cnt_q   <= '0;
            a_rd_q  <= '0;
            b_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            mask_q  <= mask_d;
            gnt_q   <= gnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            a_rd_q  <= a_rd_d;
            b_rd_q  <= b_rd_d;
        end
    end

    // Array port is fully zeroed outside the single issue cycle.
    assign issue    = (state_q == S_ISSUE) && !oor;
    assign arr_en   = issue;
    assign arr_we   = issue & we_q;
    assign arr_adr  = issue ? adr_q[ARR_AW+1:2] : '0;
    assign arr_sel  = issue ? sel_q : 4'h0;
    assign arr_dat  = issue ? dat_q : 32'h0;

    assign a_ack    = (state_q == S_RESP) & ~gnt_q;
    assign b_ack    = (state_q == S_RESP) &  gnt_q;
    assign a_rd_dat = a_rd_q;
    assign b_rd_dat = b_rd_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_toysram_cmd_arb.sv
// Directed bench for toysram_cmd_arb: single-command vector table plus round-robin,
// cfg_en masking and mid-command reset sequences, against a small array model.
module tb_toysram_cmd_arb;

    localparam int RD_LAT = 2;
    localparam int ARR_AW = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        cfg_en;
    logic              a_val, a_we, b_val, b_we;
    logic [31:0]       a_adr, a_dat, b_adr, b_dat;
    logic [3:0]        a_sel, b_sel;
    logic              a_ack, b_ack;
    logic [31:0]       a_rd_dat, b_rd_dat;
    logic              arr_en, arr_we;
    logic [ARR_AW-1:0] arr_adr;
    logic [3:0]        arr_sel;
    logic [31:0]       arr_dat, arr_rd_dat;
    logic              busy;

    always #5 clk = ~clk;

    toysram_cmd_arb #(.RD_LAT(RD_LAT), .ARR_AW(ARR_AW), .ERR_DAT(32'hDEADBEEF)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en),
        .a_val(a_val), .a_adr(a_adr), .a_we(a_we), .a_sel(a_sel), .a_dat(a_dat),
        .a_ack(a_ack), .a_rd_dat(a_rd_dat),
        .b_val(b_val), .b_adr(b_adr), .b_we(b_we), .b_sel(b_sel), .b_dat(b_dat),
        .b_ack(b_ack), .b_rd_dat(b_rd_dat),
        .arr_en(arr_en), .arr_we(arr_we), .arr_adr(arr_adr), .arr_sel(arr_sel),
        .arr_dat(arr_dat), .arr_rd_dat(arr_rd_dat), .busy(busy)
    );

    // Array model: byte-masked writes, read data valid only RD_LAT cycles after arr_en.
    logic [31:0] mem [64];
    logic [31:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= (arr_en && !arr_we) ? mem[arr_adr] : 32'h0BAD0BAD;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[4] <= 32'hCAFEF00D;
        end else if (arr_en && arr_we) begin
            for (int b = 0; b < 4; b++)
                if (arr_sel[b]) mem[arr_adr][8*b +: 8] <= arr_dat[8*b +: 8];
        end
    end
    assign arr_rd_dat = rd_pipe[RD_LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {27'd0, a_ack, b_ack, arr_en, arr_we, busy}, 32'd0);
        chk({tag, "_arr"}, {22'd0, arr_adr, arr_sel}, 32'd0);
        chk({tag, "_arr_dat"}, arr_dat, 32'd0);
        chk({tag, "_a_rd"}, a_rd_dat, 32'd0);
        chk({tag, "_b_rd"}, b_rd_dat, 32'd0);
    endtask

    int          r_lat, r_en_k;
    logic [5:0]  r_adr;
    logic        r_we, r_cross, r_leak, r_busy;
    logic [3:0]  r_sel;
    logic [31:0] r_dat, r_rd;

    // Issues one command in the cycle after the call; k counts cycles after the grant cycle.
    task automatic do_cmd(input bit side, input logic we, input logic [31:0] adr,
                          input logic [3:0] sel, input logic [31:0] dat);
        @(negedge clk);
        if (side) begin b_val = 1; b_we = we; b_adr = adr; b_sel = sel; b_dat = dat; end
        else      begin a_val = 1; a_we = we; a_adr = adr; a_sel = sel; a_dat = dat; end
        r_lat = -1; r_en_k = -1; r_cross = 0; r_leak = 0; r_busy = 0;
        r_adr = '0; r_we = 0; r_sel = '0; r_dat = '0; r_rd = '0;
        for (int k = 1; k <= 20 && r_lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) r_busy = busy;
            if (arr_en) begin
                r_en_k = (r_en_k < 0) ? k : 99;
                r_adr = arr_adr; r_we = arr_we; r_sel = arr_sel; r_dat = arr_dat;
            end else if (arr_we || arr_adr != 0 || arr_sel != 0 || arr_dat != 0) begin
                r_leak = 1;
            end
            if (side ? a_ack : b_ack) r_cross = 1;
            if (side ? b_ack : a_ack) begin
                r_lat = k;
                r_rd  = side ? b_rd_dat : a_rd_dat;
            end
        end
        a_val = 0; b_val = 0;
        @(negedge clk);
    endtask

    typedef struct {
        bit          side;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          lat;
        bit          en;
        logic [5:0]  aadr;
        logic [31:0] rd;
    } vec_t;

    vec_t vt [10];
    int   ord [4];
    int   tk [4];
    logic [31:0] rdv [4];
    int   n, a_cnt, b_cnt;
    bit   both, a_low, b_low, got;

    initial begin
        vt[0] = '{0, 0, 32'h0000_0010, 4'hF, 32'h0,          4, 1, 6'd4,  32'hCAFEF00D};
        vt[1] = '{0, 1, 32'h3000_0010, 4'hF, 32'h1234_5678,  2, 1, 6'd4,  32'h0};
        vt[2] = '{1, 0, 32'h0000_0010, 4'hF, 32'h0,          4, 1, 6'd4,  32'h1234_5678};
        vt[3] = '{1, 0, 32'h0000_1000, 4'hF, 32'h0,          2, 0, 6'd0,  32'hDEADBEEF};
        vt[4] = '{0, 1, 32'h0000_0400, 4'hF, 32'h5555_5555,  2, 0, 6'd0,  32'h0};
        vt[5] = '{0, 1, 32'h0000_0014, 4'h3, 32'hAAAA_5555,  2, 1, 6'd5,  32'h0};
        vt[6] = '{1, 0, 32'h0000_0014, 4'hF, 32'h0,          4, 1, 6'd5,  32'h1000_5555};
        vt[7] = '{0, 0, 32'hF000_00FC, 4'hF, 32'h0,          4, 1, 6'd63, 32'h1000_003F};
        vt[8] = '{1, 1, 32'h8000_0100, 4'hF, 32'h7777_7777,  2, 0, 6'd0,  32'h0};
        vt[9] = '{0, 0, 32'h0800_0000, 4'hF, 32'h0,          2, 0, 6'd0,  32'hDEADBEEF};

        rst = 1; cfg_en = 2'b11;
        a_val = 0; a_we = 0; a_adr = 0; a_sel = 0; a_dat = 0;
        b_val = 0; b_we = 0; b_adr = 0; b_sel = 0; b_dat = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            do_cmd(vt[i].side, vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat);
            chk($sformatf("v%0d_lat", i), 32'(r_lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_en_cycle", i), 32'(r_en_k), vt[i].en ? 32'd1 : 32'hFFFF_FFFF);
            chk($sformatf("v%0d_busy", i), {31'd0, r_busy}, 32'd1);
            chk($sformatf("v%0d_cross_ack", i), {31'd0, r_cross}, 32'd0);
            chk($sformatf("v%0d_arr_idle_zero", i), {31'd0, r_leak}, 32'd0);
            if (vt[i].en) chk($sformatf("v%0d_arr_adr", i), {26'd0, r_adr}, {26'd0, vt[i].aadr});
            if (vt[i].en && vt[i].we) begin
                chk($sformatf("v%0d_arr_we", i), {31'd0, r_we}, 32'd1);
                chk($sformatf("v%0d_arr_sel", i), {28'd0, r_sel}, {28'd0, vt[i].sel});
                chk($sformatf("v%0d_arr_dat", i), r_dat, vt[i].dat);
            end
            if (!vt[i].we) chk($sformatf("v%0d_rd_dat", i), r_rd, vt[i].rd);
        end

        // Both requesters hold reads from reset: expect A,B,A,B every 3+RD_LAT cycles.
        rst = 1;
        a_val = 1; a_we = 0; a_adr = 32'h10; a_sel = 4'hF;
        b_val = 1; b_we = 0; b_adr = 32'h14; b_sel = 4'hF;
        @(negedge clk); @(negedge clk);
        rst = 0;
        n = 0; both = 0; a_low = 0; b_low = 0;
        for (int i = 0; i < 4; i++) begin ord[i] = -1; tk[i] = -100; rdv[i] = 'x; end
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (a_ack && b_ack) both = 1;
            if (a_ack) begin
                ord[n] = 0; tk[n] = c; rdv[n] = a_rd_dat; n++; a_val = 0; a_low = 1;
            end else if (a_low) begin
                a_val = 1; a_low = 0;
            end
            if (b_ack && !a_ack) begin
                ord[n] = 1; tk[n] = c; rdv[n] = b_rd_dat; n++; b_val = 0; b_low = 1;
            end else if (b_low) begin
                b_val = 1; b_low = 0;
            end
        end
        a_val = 0; b_val = 0;
        chk("rr_count", 32'(n), 32'd4);
        chk("rr_both_ack", {31'd0, both}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_order%0d", i), 32'(ord[i]), 32'(i % 2));
            chk($sformatf("rr_rd%0d", i), rdv[i], (i % 2) ? 32'h1000_0005 : 32'hCAFEF00D);
        end
        for (int i = 1; i < 4; i++)
            chk($sformatf("rr_gap%0d", i), 32'(tk[i] - tk[i-1]), 32'(3 + RD_LAT));
        repeat (2) @(negedge clk);

        // cfg_en=10: only B is served, A stays pending until re-enabled.
        cfg_en = 2'b10;
        a_val = 1; a_we = 0; a_adr = 32'h10; a_sel = 4'hF;
        b_val = 1; b_we = 1; b_adr = 32'h18; b_sel = 4'hF; b_dat = 32'h1111_2222;
        a_cnt = 0; b_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (a_ack) a_cnt++;
            if (b_ack) begin b_cnt++; b_val = 0; end
        end
        chk("cfg_a_acks", 32'(a_cnt), 32'd0);
        chk("cfg_b_acks", 32'(b_cnt), 32'd1);
        cfg_en = 2'b11;
        got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            if (a_ack) begin got = 1; chk("cfg_a_rd", a_rd_dat, 32'hCAFEF00D); end
        end
        chk("cfg_a_served", {31'd0, got}, 32'd1);
        a_val = 0;
        repeat (2) @(negedge clk);

        // Reset during WAIT of an A read abandons it.
        a_val = 1; a_we = 0; a_adr = 32'h14; a_sel = 4'hF;
        @(negedge clk);
        chk("rw_issue_en", {31'd0, arr_en}, 32'd1);
        @(negedge clk);
        chk("rw_wait_busy", {31'd0, busy}, 32'd1);
        rst = 1; a_val = 0;
        @(negedge clk);
        chk_zero("rw_after_rst");
        rst = 0;
        a_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_ack) a_cnt++;
        end
        chk("rw_no_ack", 32'(a_cnt), 32'd0);
        do_cmd(0, 1, 32'h18, 4'hF, 32'h3333_4444);
        chk("rw_fresh_lat", 32'(r_lat), 32'd2);
        chk("rw_fresh_en", 32'(r_en_k), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
